// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: digit load bus and display drive bus of the scan controller.
// master = datapath/display side, slave = scan controller.
// Signals: ena, load, digits_in, dp_in (to controller);
//          bcd_out, digit_sel, dp_out, blank, frame_done (from controller).
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    ena;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    dp_out;
  logic                    blank;
  logic                    frame_done;

  modport master (
    output ena,
    output load,
    output digits_in,
    output dp_in,
    input  bcd_out,
    input  digit_sel,
    input  dp_out,
    input  blank,
    input  frame_done
  );

  modport slave (
    input  ena,
    input  load,
    input  digits_in,
    input  dp_in,
    output bcd_out,
    output digit_sel,
    output dp_out,
    output blank,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexes NUM_DIGITS BCD digits onto one seg7 decoder,
// with a blank gap before each digit and frame-aligned value updates.
// Ports: clk, rst_n (sync, active low), bus (seg_scan_ctrl_if.slave).
// Option: define LZ_BLANK_EN for leading-zero suppression.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 10000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int MAXC =
    (DWELL_CYCLES > BLANK_CYCLES) ?
    DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW =
    (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST =
    CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_t;

  state_t r_state;
  state_t w_nxt_state;

  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_nxt_idx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt_cnt;
  logic          w_frame_start;
  logic          w_wrap;

  logic [DW-1:0]         r_shadow;
  logic [NUM_DIGITS-1:0] r_shadow_dp;
  logic [DW-1:0]         r_active;
  logic [NUM_DIGITS-1:0] r_active_dp;
  logic                  r_pending;

  logic [3:0]            r_bcd;
  logic [NUM_DIGITS-1:0] r_sel;
  logic                  r_dp;
  logic                  r_blank;
  logic                  r_frame_done;

  logic [3:0]            w_bcd;
  logic [NUM_DIGITS-1:0] w_sel;
  logic                  w_dp;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_sup;
  logic [IW+1:0]         w_off;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_idx     = r_idx;
    w_nxt_cnt     = r_cnt + CW'(1);
    w_frame_start = 1'b0;
    w_wrap        = 1'b0;
    if (!bus.ena) begin
      w_nxt_state = S_IDLE;
      w_nxt_idx   = '0;
      w_nxt_cnt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_nxt_state   = S_BLANK;
          w_nxt_idx     = '0;
          w_nxt_cnt     = '0;
          w_frame_start = 1'b1;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_nxt_state = S_DRIVE;
            w_nxt_cnt   = '0;
          end
        end
        S_DRIVE: begin
          if (r_cnt == DWELL_LAST) begin
            w_nxt_state = S_BLANK;
            w_nxt_cnt   = '0;
            if (r_idx == IDX_LAST) begin
              w_nxt_idx     = '0;
              w_frame_start = 1'b1;
              w_wrap        = 1'b1;
            end else begin
              w_nxt_idx = r_idx + IW'(1);
            end
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_idx   = '0;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // A load coinciding with a frame start bypasses the
  // shadow so the new frame already shows it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_active    <= '0;
      r_active_dp <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (bus.load) begin
        r_shadow    <= bus.digits_in;
        r_shadow_dp <= bus.dp_in;
        r_pending   <= 1'b1;
      end
      if (w_frame_start) begin
        r_pending <= 1'b0;
        if (bus.load) begin
          r_active    <= bus.digits_in;
          r_active_dp <= bus.dp_in;
        end else if (r_pending) begin
          r_active    <= r_shadow;
          r_active_dp <= r_shadow_dp;
        end
      end
    end
  end

`ifdef LZ_BLANK_EN
  // Suppression runs from the top digit down and
  // stops at the first non-zero digit or set dp.
  always_comb begin
    logic l_run;
    w_sup = '0;
    l_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      l_run = l_run &&
        (r_active[4*i +: 4] == 4'd0) &&
        !r_active_dp[i];
      w_sup[i] = l_run;
    end
  end
`else
  assign w_sup = '0;
`endif

  assign w_off = {w_nxt_idx, 2'b00};

  // Outputs are decoded from the next state so they
  // line up with the state once registered.
  always_comb begin
    w_bcd   = '0;
    w_sel   = '0;
    w_dp    = 1'b0;
    w_blank = 1'b1;
    if (w_nxt_state == S_DRIVE) begin
      w_bcd = r_active[w_off +: 4];
      if (!w_sup[w_nxt_idx]) begin
        w_sel   = NUM_DIGITS'(1) << w_nxt_idx;
        w_dp    = r_active_dp[w_nxt_idx];
        w_blank = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd        <= '0;
      r_sel        <= '0;
      r_dp         <= 1'b0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_bcd        <= w_bcd;
      r_sel        <= w_sel;
      r_dp         <= w_dp;
      r_blank      <= w_blank;
      r_frame_done <= w_wrap;
    end
  end

  assign bus.bcd_out    = r_bcd;
  assign bus.digit_sel  = r_sel;
  assign bus.dp_out     = r_dp;
  assign bus.blank      = r_blank;
  assign bus.frame_done = r_frame_done;

endmodule
